hash_bucket_lookup: RTL and testbench

HASH_BUCKET_LOOKUP -- requirements
Module: hash_bucket_lookup

---
 rtl/hash_bucket_lookup.sv | 166 ++++++++++++++++
 tb/tb_hash_bucket_lookup.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_bucket_lookup.sv
// Purpose: pops one key hash per lookup, reads its 8-way bucket, reports the lowest matching way.
// Latency: 4 cycles pop-to-result minimum; one lookup in flight; optional stats via HASH_LOOKUP_STATS_EN.
// Backpressure: holds oMemRdReq until iMemRdAck and the result until iResReady; no pop while busy.
module hash_bucket_lookup #(
    parameter int KEYHASH_WIDTH1 = 28,
    parameter int KEYHASH_WIDTH2 = 24,
    parameter int KEYHASH_WIDTH3 = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      oRdHashClk,
    input  logic                      iRdHashEmpty,
    output logic                      oRdHashFifo_en,
    input  logic [KEYHASH_WIDTH1-1:0] iKeyHash_1,
    input  logic [KEYHASH_WIDTH2-1:0] iKeyHash_2,
    input  logic [KEYHASH_WIDTH3-1:0] iKeyHash_3,
    output logic                      oMemRdReq,
    output logic [KEYHASH_WIDTH1-1:0] oMemRdAddr,
    input  logic                      iMemRdAck,
    input  logic                      iMemRdValid,
    input  logic [255:0]              iMemRdData,
    output logic                      oResValid,
    input  logic                      iResReady,
    output logic                      oResHit,
    output logic [2:0]                oResWay,
    output logic [KEYHASH_WIDTH3-1:0] oResSlot,
    output logic [KEYHASH_WIDTH1-1:0] oResAddr,
    output logic [31:0]               oHitCnt,
    output logic [31:0]               oMissCnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        CMP   = 3'd4,
        OUT   = 3'd5
    } state_t;

    state_t                    state;
    logic [KEYHASH_WIDTH2-1:0] hash2Q;
    logic [KEYHASH_WIDTH3-1:0] hash3Q;
    logic [255:0]              bucketQ;
    logic [23:0]               sigRef;
    logic                      cmpHit;
    logic [2:0]                cmpWay;
    logic                      unusedResvBits;

    // The FIFO shares our clock.
    assign oRdHashClk = clk;

    // Pop only from IDLE, and never while reset is held.
    assign oRdHashFifo_en = rst && (state == IDLE) && !iRdHashEmpty;

    // Signature field is 24 bits wide in every bucket entry.
    assign sigRef = 24'(hash2Q);

    // Scan high to low so the lowest matching way wins.
    always_comb begin
        cmpHit = 1'b0;
        cmpWay = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bucketQ[32*i+31] && (bucketQ[32*i +: 24] == sigRef)) begin
                cmpHit = 1'b1;
                cmpWay = 3'(i);
            end
        end
    end

    // Reserved entry bits carry no meaning for the lookup.
    always_comb begin
        unusedResvBits = 1'b0;
        for (int i = 0; i < 8; i++) begin
            unusedResvBits = unusedResvBits ^ (^bucketQ[32*i+24 +: 7]);
        end
    end

    // Lookup sequencer; oMemRdAddr doubles as the latched bucket address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hash2Q     <= '0;
            hash3Q     <= '0;
            bucketQ    <= '0;
            oMemRdReq  <= 1'b0;
            oMemRdAddr <= '0;
            oResValid  <= 1'b0;
            oResHit    <= 1'b0;
            oResWay    <= 3'd0;
            oResSlot   <= '0;
            oResAddr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!iRdHashEmpty) state <= LATCH;
                end
                LATCH: begin
                    oMemRdAddr <= iKeyHash_1;
                    hash2Q     <= iKeyHash_2;
                    hash3Q     <= iKeyHash_3;
                    oMemRdReq  <= 1'b1;
                    state      <= REQ;
                end
                REQ: begin
                    if (iMemRdAck) begin
                        oMemRdReq <= 1'b0;
                        if (iMemRdValid) begin
                            bucketQ <= iMemRdData;
                            state   <= CMP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (iMemRdValid) begin
                        bucketQ <= iMemRdData;
                        state   <= CMP;
                    end
                end
                CMP: begin
                    oResHit   <= cmpHit;
                    oResWay   <= cmpWay;
                    oResSlot  <= hash3Q;
                    oResAddr  <= oMemRdAddr;
                    oResValid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (iResReady) begin
                        oResValid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HASH_LOOKUP_STATS_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;

    // Saturating hit/miss counters, bumped once per accepted result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitCnt  <= '0;
            missCnt <= '0;
        end else if ((state == OUT) && iResReady) begin
            if (oResHit) begin
                if (hitCnt != 32'hFFFF_FFFF) hitCnt <= hitCnt + 32'd1;
            end else begin
                if (missCnt != 32'hFFFF_FFFF) missCnt <= missCnt + 32'd1;
            end
        end
    end

    assign oHitCnt  = hitCnt;
    assign oMissCnt = missCnt;
`else
    assign oHitCnt  = 32'd0;
    assign oMissCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hash_bucket_lookup.sv
// Purpose: directed, table-driven check of hash_bucket_lookup with a FIFO model and scripted memory.
// Latency: checks the 4-cycle pop-to-result path plus delayed ack/data and held-result cases.
// Backpressure: exercises held iResReady, delayed ack, mid-lookup reset and stray memory valids.
module tb_hash_bucket_lookup;

    typedef struct {
        logic [27:0]  h1;
        logic [23:0]  h2;
        logic [4:0]   h3;
        logic [255:0] bucket;
        int           ackDly;
        int           valDly;
        int           rdyDly;
        bit           spur;
        bit           expHit;
        logic [2:0]   expWay;
    } vec_t;

    localparam int NV = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         oRdHashClk;
    logic         iRdHashEmpty;
    logic         oRdHashFifo_en;
    logic [27:0]  kh1 = '0;
    logic [23:0]  kh2 = '0;
    logic [4:0]   kh3 = '0;
    logic         oMemRdReq;
    logic [27:0]  oMemRdAddr;
    logic         iMemRdAck = 1'b0;
    logic         iMemRdValid = 1'b0;
    logic [255:0] iMemRdData = '1;
    logic         oResValid;
    logic         iResReady = 1'b0;
    logic         oResHit;
    logic [2:0]   oResWay;
    logic [4:0]   oResSlot;
    logic [27:0]  oResAddr;
    logic [31:0]  oHitCnt;
    logic [31:0]  oMissCnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int popCyc = 0;
    int popCnt = 0;
    int wrPtr = 0;
    int rdPtr = 0;
    int expHits = 0;
    int expMiss = 0;
    logic [56:0] fifoMem [16];
    vec_t vecs [NV];

    hash_bucket_lookup dut (
        .clk(clk), .rst(rst), .oRdHashClk(oRdHashClk),
        .iRdHashEmpty(iRdHashEmpty), .oRdHashFifo_en(oRdHashFifo_en),
        .iKeyHash_1(kh1), .iKeyHash_2(kh2), .iKeyHash_3(kh3),
        .oMemRdReq(oMemRdReq), .oMemRdAddr(oMemRdAddr), .iMemRdAck(iMemRdAck),
        .iMemRdValid(iMemRdValid), .iMemRdData(iMemRdData),
        .oResValid(oResValid), .iResReady(iResReady),
        .oResHit(oResHit), .oResWay(oResWay), .oResSlot(oResSlot), .oResAddr(oResAddr),
        .oHitCnt(oHitCnt), .oMissCnt(oMissCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: show-ahead free, data appears the cycle after the pop.
    assign iRdHashEmpty = (wrPtr == rdPtr);
    always @(posedge clk) begin
        if (oRdHashFifo_en) begin
            {kh1, kh2, kh3} <= fifoMem[rdPtr % 16];
            rdPtr  <= rdPtr + 1;
            popCnt <= popCnt + 1;
            popCyc <= cyc;
        end
    end

    function automatic logic [31:0] ent(input bit v, input logic [6:0] resv, input logic [23:0] sig);
        return {v, resv, sig};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input vec_t v);
        fifoMem[wrPtr % 16] = {v.h1, v.h2, v.h3};
        wrPtr++;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_en"},      64'(oRdHashFifo_en), 0);
        check({tag, "_req"},     64'(oMemRdReq), 0);
        check({tag, "_addr"},    64'(oMemRdAddr), 0);
        check({tag, "_rvalid"},  64'(oResValid), 0);
        check({tag, "_hit"},     64'(oResHit), 0);
        check({tag, "_way"},     64'(oResWay), 0);
        check({tag, "_slot"},    64'(oResSlot), 0);
        check({tag, "_raddr"},   64'(oResAddr), 0);
        check({tag, "_hitcnt"},  64'(oHitCnt), 0);
        check({tag, "_misscnt"}, 64'(oMissCnt), 0);
    endtask

    // Serve one lookup whose hash is already queued; called and returns at a negedge.
    task automatic lookup(input vec_t v, input int p0);
        int n;
        bit err;
        n = 0;
        while (!oMemRdReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 64'(oMemRdReq), 1);
        check("req_addr", 64'(oMemRdAddr), 64'(v.h1));
        err = 1'b0;
        for (int k = 0; k < v.ackDly; k++) begin
            @(negedge clk);
            if (oMemRdReq !== 1'b1 || oMemRdAddr !== v.h1) err = 1'b1;
        end
        if (v.ackDly > 0) check("addr_stable", 64'(err), 0);
        iMemRdAck = 1'b1;
        if (v.valDly == 0) begin
            iMemRdValid = 1'b1;
            iMemRdData  = v.bucket;
        end
        @(negedge clk);
        iMemRdAck   = 1'b0;
        iMemRdValid = 1'b0;
        iMemRdData  = '1;
        check("req_dropped", 64'(oMemRdReq), 0);
        if (v.valDly > 0) begin
            repeat (v.valDly - 1) @(negedge clk);
            iMemRdValid = 1'b1;
            iMemRdData  = v.bucket;
            @(negedge clk);
            iMemRdValid = 1'b0;
            iMemRdData  = '1;
        end
        n = 0;
        while (!oResValid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("res_valid", 64'(oResValid), 1);
        if (v.ackDly == 0 && v.valDly == 0) check("latency", 64'(cyc - popCyc), 4);
        check("res_hit",  64'(oResHit), 64'(v.expHit));
        check("res_way",  64'(oResWay), 64'(v.expWay));
        check("res_slot", 64'(oResSlot), 64'(v.h3));
        check("res_addr", 64'(oResAddr), 64'(v.h1));
        check("single_pop", 64'(popCnt - p0), 1);
        err = 1'b0;
        for (int k = 0; k < v.rdyDly; k++) begin
            @(negedge clk);
            if (oResValid !== 1'b1 || oResHit !== v.expHit || oResWay !== v.expWay ||
                oResSlot !== v.h3 || oResAddr !== v.h1 || oRdHashFifo_en !== 1'b0) err = 1'b1;
        end
        if (v.rdyDly > 0) check("hold_stable", 64'(err), 0);
        iResReady = 1'b1;
        @(negedge clk);
        iResReady = 1'b0;
        check("res_cleared", 64'(oResValid), 0);
        if (v.rdyDly > 0) check("pop_after_hs", 64'(oRdHashFifo_en), 1);
        if (v.expHit) expHits++;
        else          expMiss++;
    endtask

    initial begin
        vec_t r1, r2;
        int nextPush;
        int p0;

        // v0: single valid match in entry 5, zero-wait memory
        vecs[0] = '{h1: 28'h0000123, h2: 24'hABCDEF, h3: 5'h11, bucket: '0, ackDly: 0,
                    valDly: 0, rdyDly: 0, spur: 0, expHit: 1, expWay: 3'd5};
        for (int i = 0; i < 8; i++) vecs[0].bucket[32*i +: 32] = ent(1, 7'h0, 24'(i));
        vecs[0].bucket[32*5 +: 32] = ent(1, 7'h0, 24'hABCDEF);
        // v1: entries 2 (invalid) and 6 match -> way 6; result held 10 cycles with FIFO non-empty
        vecs[1] = '{h1: 28'hFEDCBA9, h2: 24'h123456, h3: 5'h1F, bucket: '0, ackDly: 0,
                    valDly: 0, rdyDly: 10, spur: 0, expHit: 1, expWay: 3'd6};
        for (int i = 0; i < 8; i++) vecs[1].bucket[32*i +: 32] = ent(1, 7'h0, 24'h654321);
        vecs[1].bucket[32*2 +: 32] = ent(0, 7'h0, 24'h123456);
        vecs[1].bucket[32*6 +: 32] = ent(1, 7'h0, 24'h123456);
        // v2: entries 2 and 6 both valid matches -> lowest wins
        vecs[2] = vecs[1];
        vecs[2].h1 = 28'h5A5A5A5; vecs[2].h3 = 5'h00; vecs[2].rdyDly = 0; vecs[2].expWay = 3'd2;
        vecs[2].bucket[32*2 +: 32] = ent(1, 7'h0, 24'h123456);
        // v3: signature present everywhere but nothing valid -> miss
        vecs[3] = '{h1: 28'h0000001, h2: 24'h777777, h3: 5'h0A, bucket: '0, ackDly: 0,
                    valDly: 0, rdyDly: 0, spur: 0, expHit: 0, expWay: 3'd0};
        for (int i = 0; i < 8; i++) vecs[3].bucket[32*i +: 32] = ent(0, 7'h0, 24'h777777);
        // v4: top entry with reserved bits set still matches; neighbours one off
        vecs[4] = '{h1: 28'hFFFFFFF, h2: 24'hC0FFEE, h3: 5'h15, bucket: '0, ackDly: 0,
                    valDly: 0, rdyDly: 0, spur: 0, expHit: 1, expWay: 3'd7};
        for (int i = 0; i < 8; i++) vecs[4].bucket[32*i +: 32] = ent(1, 7'h0, 24'hC0FFEF);
        vecs[4].bucket[32*7 +: 32] = ent(1, 7'h7F, 24'hC0FFEE);
        // v5: slow memory (ack +3, data +5) with a stray valid while idle; hit in way 0
        vecs[5] = '{h1: 28'h0ABCDEF, h2: 24'h000000, h3: 5'h03, bucket: '0, ackDly: 3,
                    valDly: 5, rdyDly: 0, spur: 1, expHit: 1, expWay: 3'd0};
        vecs[5].bucket[31:0] = ent(1, 7'h0, 24'h000000);
        // v6: all valid, signatures one bit off -> miss, ack after 1 cycle
        vecs[6] = '{h1: 28'h0000123, h2: 24'hABCDEF, h3: 5'h07, bucket: '0, ackDly: 1,
                    valDly: 0, rdyDly: 0, spur: 0, expHit: 0, expWay: 3'd0};
        for (int i = 0; i < 8; i++) vecs[6].bucket[32*i +: 32] = ent(1, 7'h0, 24'hABCDEE);

        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b1;
        @(negedge clk);

        nextPush = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].spur) begin
                p0 = popCnt;
                iMemRdValid = 1'b1;
                iMemRdData  = vecs[i].bucket;
                @(negedge clk);
                iMemRdValid = 1'b0;
                iMemRdData  = '1;
                repeat (2) @(negedge clk);
                check("spur_no_result", 64'(oResValid), 0);
                check("spur_no_pop", 64'(popCnt - p0), 0);
            end
            p0 = popCnt;
            while (nextPush <= i) begin
                push(vecs[nextPush]);
                nextPush++;
            end
            if (vecs[i].rdyDly > 0 && i + 1 < NV && nextPush == i + 1) begin
                push(vecs[i + 1]);
                nextPush++;
            end
            lookup(vecs[i], p0);
        end

        // Reset while waiting for bucket data, with the next hash already queued.
        r1 = '{h1: 28'h1111111, h2: 24'h222222, h3: 5'h03, bucket: '0, ackDly: 0,
               valDly: 0, rdyDly: 0, spur: 0, expHit: 1, expWay: 3'd1};
        r1.bucket[32*1 +: 32] = ent(1, 7'h0, 24'h222222);
        r2 = '{h1: 28'h3333333, h2: 24'h444444, h3: 5'h04, bucket: '0, ackDly: 0,
               valDly: 0, rdyDly: 0, spur: 0, expHit: 1, expWay: 3'd4};
        r2.bucket = r1.bucket;
        r2.bucket[32*4 +: 32] = ent(1, 7'h0, 24'h444444);
        push(r1);
        begin
            int n;
            n = 0;
            while (!oMemRdReq && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("rst_req_seen", 64'(oMemRdReq), 1);
        iMemRdAck = 1'b1;
        @(negedge clk);
        iMemRdAck = 1'b0;
        push(r2);
        rst = 1'b0;
        #1;
        checkAllZero("midrst");
        expHits = 0;
        expMiss = 0;
        repeat (2) @(negedge clk);
        check("midrst_en_held", 64'(oRdHashFifo_en), 0);
        check("midrst_no_pop", 64'(iRdHashEmpty), 0);
        p0 = popCnt;
        rst = 1'b1;
        iMemRdValid = 1'b1;
        iMemRdData  = r1.bucket;
        repeat (2) @(negedge clk);
        iMemRdValid = 1'b0;
        iMemRdData  = '1;
        check("late_valid_no_result", 64'(oResValid), 0);
        lookup(r2, p0);

`ifdef HASH_LOOKUP_STATS_EN
        check("stats_hits", 64'(oHitCnt), 64'(expHits));
        check("stats_miss", 64'(oMissCnt), 64'(expMiss));
        dut.hitCnt = 32'hFFFF_FFFF;
        p0 = popCnt;
        push(vecs[0]);
        lookup(vecs[0], p0);
        check("stats_hit_sat", 64'(oHitCnt), 64'h0000_0000_FFFF_FFFF);
        check("stats_miss_kept", 64'(oMissCnt), 64'(expMiss));
`else
        check("stats_off_hits", 64'(oHitCnt), 0);
        check("stats_off_miss", 64'(oMissCnt), 0);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so a stuck DUT still produces a summary.
    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: got no completion, want finish before 200000");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
